mem_access_initiator: RTL and testbench

- Initiator side of the data-memory interface: accepts one load/store request at a time from the ARMv8 memory-access stage, drives a valid/ack handshake to a variable-latency data memory, and returns a single response pulse.
- Sits between the execute/memory stage (address from ALU result, store data from the register file) and the data-memory responder.
- Checks alignment and range before issuing. Holds the memory request stable until it is acknowledged.

---
 rtl/mem_access_initiator.sv | 163 ++++++++++++++++
 tb/tb_mem_access_initiator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_initiator.sv
// Data-memory initiator: one load/store at a time, valid/ack to memory,
// single-cycle response pulse with alignment/range/timeout error codes.
//
// Ports:
//   clock, reset_n            rising-edge clock, async active-low reset
//   reqValid/reqReady         pipeline request handshake (ready only in IDLE)
//   reqWrite, reqAddress,
//   reqWriteData              request fields, sampled on accept
//   rspValid, rspData,
//   rspError, rspErrCode      one-cycle response (00 ok, 01 misaligned,
//                             10 out of range, 11 timeout)
//   memReq, memWrite,
//   memAddress, memWriteData  memory request, held stable until memAck
//   memAck, memReadData       memory completion pulse and load data
//
// Optional build macro MEM_ACCESS_TIMEOUT_EN adds a watchdog that abandons
// an ISSUE after TIMEOUT_CYCLES cycles without memAck (code 11).
module mem_access_initiator #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int MEM_DEPTH_LOG2 = 6,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      reqValid,
    output logic                      reqReady,
    input  logic                      reqWrite,
    input  logic [ADDR_W-1:0]         reqAddress,
    input  logic [DATA_W-1:0]         reqWriteData,
    output logic                      rspValid,
    output logic [DATA_W-1:0]         rspData,
    output logic                      rspError,
    output logic [1:0]                rspErrCode,
    output logic                      memReq,
    output logic                      memWrite,
    output logic [MEM_DEPTH_LOG2-1:0] memAddress,
    output logic [DATA_W-1:0]         memWriteData,
    input  logic                      memAck,
    input  logic [DATA_W-1:0]         memReadData
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    state_t state;

    logic misaligned;
    logic outOfRange;

    assign misaligned = |reqAddress[2:0];
    // Any set bit above the doubleword index puts the access past the end.
    assign outOfRange = |reqAddress[ADDR_W-1:MEM_DEPTH_LOG2+3];

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    logic [CNT_W-1:0] waitCount;
    logic             timedOut;

    // The count still reads LIMIT-1 in the last allowed ISSUE cycle, so
    // memReq is high for exactly TIMEOUT_CYCLES cycles.
    assign timedOut = (waitCount == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            reqReady     <= 1'b0;
            rspValid     <= 1'b0;
            rspData      <= '0;
            rspError     <= 1'b0;
            rspErrCode   <= 2'b00;
            memReq       <= 1'b0;
            memWrite     <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            waitCount    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    // reqReady comes up one edge after reset release.
                    if (!reqReady) begin
                        reqReady <= 1'b1;
                    end else if (reqValid) begin
                        reqReady <= 1'b0;
                        if (misaligned) begin
                            state      <= RESP;
                            rspValid   <= 1'b1;
                            rspError   <= 1'b1;
                            rspErrCode <= ERR_MISALIGN;
                        end else if (outOfRange) begin
                            state      <= RESP;
                            rspValid   <= 1'b1;
                            rspError   <= 1'b1;
                            rspErrCode <= ERR_RANGE;
                        end else begin
                            state        <= ISSUE;
                            memReq       <= 1'b1;
                            memWrite     <= reqWrite;
                            memAddress   <=
                                reqAddress[MEM_DEPTH_LOG2+2:3];
                            memWriteData <= reqWriteData;
`ifdef MEM_ACCESS_TIMEOUT_EN
                            waitCount    <= '0;
`endif
                        end
                    end
                end

                ISSUE: begin
                    if (memAck) begin
                        state        <= RESP;
                        rspValid     <= 1'b1;
                        rspData      <= memWrite ? '0 : memReadData;
                        memReq       <= 1'b0;
                        memWrite     <= 1'b0;
                        memAddress   <= '0;
                        memWriteData <= '0;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (timedOut) begin
                        state        <= RESP;
                        rspValid     <= 1'b1;
                        rspError     <= 1'b1;
                        rspErrCode   <= ERR_TIMEOUT;
                        memReq       <= 1'b0;
                        memWrite     <= 1'b0;
                        memAddress   <= '0;
                        memWriteData <= '0;
                    end else begin
                        waitCount <= waitCount + CNT_W'(1);
                    end
`endif
                end

                RESP: begin
                    // Response fields return to zero with the pulse.
                    state      <= IDLE;
                    reqReady   <= 1'b1;
                    rspValid   <= 1'b0;
                    rspData    <= '0;
                    rspError   <= 1'b0;
                    rspErrCode <= 2'b00;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Randomized bench for mem_access_initiator against a transaction-level
// model: expected codes and data come from address arithmetic and a shadow memory.
module tb_mem_access_initiator;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int DLOG2   = 6;
    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 16;

    logic              clock;
    logic              reset_n;
    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic [ADDR_W-1:0] reqAddress;
    logic [DATA_W-1:0] reqWriteData;
    logic              rspValid;
    logic [DATA_W-1:0] rspData;
    logic              rspError;
    logic [1:0]        rspErrCode;
    logic              memReq;
    logic              memWrite;
    logic [DLOG2-1:0]  memAddress;
    logic [DATA_W-1:0] memWriteData;
    logic              memAck;
    logic [DATA_W-1:0] memReadData;

    mem_access_initiator #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MEM_DEPTH_LOG2(DLOG2),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .reqValid(reqValid),
        .reqReady(reqReady),
        .reqWrite(reqWrite),
        .reqAddress(reqAddress),
        .reqWriteData(reqWriteData),
        .rspValid(rspValid),
        .rspData(rspData),
        .rspError(rspError),
        .rspErrCode(rspErrCode),
        .memReq(memReq),
        .memWrite(memWrite),
        .memAddress(memAddress),
        .memWriteData(memWriteData),
        .memAck(memAck),
        .memReadData(memReadData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checkCount = 0;
    int passCount  = 0;

    // ram: what the responder holds; refMem: what the pipeline expects.
    logic [DATA_W-1:0] ram    [DEPTH];
    logic [DATA_W-1:0] refMem [DEPTH];

    task automatic checkEq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic scrambleReq();
        reqWrite     = 1'($urandom);
        reqAddress   = rnd64();
        reqWriteData = rnd64();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            reqValid    = 1'b0;
            scrambleReq();
            memAck      = 1'($urandom);
            memReadData = rnd64();
            @(negedge clock);
            checkEq("idleRspValid", rspValid, 0);
            checkEq("idleRspData", rspData, 0);
            checkEq("idleMemReq", memReq, 0);
            checkEq("idleReady", reqReady, 1);
        end
        memAck = 1'b0;
    endtask

    task automatic doAccess(input logic wr, input logic [63:0] addr,
                            input logic [63:0] wdata, input int waits);
        int code;
        int idx;
        code = 0;
        if (addr % 8 != 0) code = 1;
        else if (addr / 8 >= DEPTH) code = 2;
        idx = int'((addr / 8) % DEPTH);

        checkEq("acceptReady", reqReady, 1);
        reqValid     = 1'b1;
        reqWrite     = wr;
        reqAddress   = addr;
        reqWriteData = wdata;
        memAck       = 1'($urandom);
        memReadData  = rnd64();
        @(negedge clock);
        reqValid = 1'b0;
        scrambleReq();
        memAck = 1'b0;

        if (code != 0) begin
            checkEq("errMemReq", memReq, 0);
            checkEq("errRspValid", rspValid, 1);
            checkEq("errRspError", rspError, 1);
            checkEq("errCode", rspErrCode, code);
            checkEq("errRspData", rspData, 0);
        end else begin
            for (int w = 0; w <= waits; w++) begin
                checkEq("issMemReq", memReq, 1);
                checkEq("issMemWrite", memWrite, wr);
                checkEq("issMemAddr", memAddress, idx);
                if (wr) checkEq("issWdata", memWriteData, wdata);
                checkEq("issRspValid", rspValid, 0);
                checkEq("issReady", reqReady, 0);
                memAck = (w == waits);
                memReadData = rnd64();
                if (memAck) begin
                    if (memWrite) ram[memAddress] = memWriteData;
                    else memReadData = ram[memAddress];
                end
                @(negedge clock);
                memAck = 1'b0;
                memReadData = rnd64();
            end
            checkEq("rspMemReq", memReq, 0);
            checkEq("rspValid", rspValid, 1);
            checkEq("rspError", rspError, 0);
            checkEq("rspCode", rspErrCode, 0);
            checkEq("rspData", rspData, wr ? 64'd0 : refMem[idx]);
            if (wr) refMem[idx] = wdata;
        end

        @(negedge clock);
        checkEq("postRspValid", rspValid, 0);
        checkEq("postRspData", rspData, 0);
        checkEq("postReady", reqReady, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] addr;
        int kind;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]    = rnd64();
            refMem[i] = ram[i];
        end
        reset_n     = 1'b0;
        reqValid    = 1'b0;
        reqWrite    = 1'b0;
        reqAddress  = '0;
        reqWriteData = '0;
        memAck      = 1'b0;
        memReadData = '0;

        repeat (2) @(negedge clock);
        checkEq("rstReady", reqReady, 0);
        checkEq("rstRspValid", rspValid, 0);
        checkEq("rstRspData", rspData, 0);
        checkEq("rstErr", {rspError, rspErrCode}, 0);
        checkEq("rstMemReq", memReq, 0);
        checkEq("rstMemBus", {memWrite, memAddress, memWriteData}, 0);
        reset_n = 1'b1;
        @(negedge clock);
        checkEq("relReady", reqReady, 1);

        doAccess(1'b1, 64'h18, 64'hDEADBEEF, 2);
        doAccess(1'b0, 64'h18, 64'h0, 0);
        doAccess(1'b0, 64'h1C, 64'h0, 0);
        doAccess(1'b0, 64'h200, 64'h0, 0);
        doAccess(1'b1, 64'h1F8, 64'h0123456789ABCDEF, 1);
        doAccess(1'b0, 64'h1F8, 64'h0, 3);
        idleCycles(3);

        reqValid   = 1'b1;
        reqWrite   = 1'b0;
        reqAddress = 64'h40;
        @(negedge clock);
        reqValid = 1'b0;
        checkEq("midMemReq", memReq, 1);
        reset_n = 1'b0;
        #1;
        checkEq("midRstMemReq", memReq, 0);
        checkEq("midRstReady", reqReady, 0);
        @(negedge clock);
        reset_n = 1'b1;
        memAck = 1'b1;
        memReadData = rnd64();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkEq("postRstRsp", rspValid, 0);
            checkEq("postRstMemReq", memReq, 0);
        end
        memAck = 1'b0;
        doAccess(1'b0, 64'h40, 64'h0, 1);

`ifdef MEM_ACCESS_TIMEOUT_EN
        begin
            int n;
            reqValid   = 1'b1;
            reqWrite   = 1'b0;
            reqAddress = 64'h08;
            @(negedge clock);
            reqValid = 1'b0;
            n = 0;
            while (memReq && n < 40) begin
                n++;
                @(negedge clock);
            end
            checkEq("toLength", n, TIMEOUT);
            checkEq("toRspValid", rspValid, 1);
            checkEq("toRspError", rspError, 1);
            checkEq("toCode", rspErrCode, 3);
            checkEq("toRspData", rspData, 0);
            @(negedge clock);
            doAccess(1'b0, 64'h08, 64'h0, TIMEOUT - 1);
        end
`endif

        for (int t = 0; t < 150; t++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                addr = 64'($urandom_range(0, DEPTH - 1)) * 8
                     + 64'($urandom_range(1, 7));
            end else if (kind == 1) begin
                addr = ($urandom % 2 == 1) ? 64'h200
                     : ((rnd64() | 64'h200) & ~64'h7);
            end else begin
                addr = 64'($urandom_range(0, DEPTH - 1)) * 8;
            end
            doAccess(1'($urandom), addr, rnd64(),
                     int'($urandom_range(0, 3)));
            idleCycles(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
